axi4_lite_slave_regs: RTL and testbench

AXI4-Lite slave (responder) terminating the five channels driven by the team's AXI4-Lite master. It backs a bank of 32-bit control/status registers with byte-strobe writes, and returns OKAY or SLVERR responses. It sits on the far side of the master's AW/W/B/AR/R channels, and its channel behaviour must satisfy the existing protocol assertion set: handshake, stability and response-value checks.

---
 rtl/axi4_lite_pkg.sv | 32 +++
 rtl/axi4_lite_regfile.sv | 33 +++
 rtl/axi4_lite_slave_regs.sv | 147 ++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, channel FSM states and the byte-strobe merge helper.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register bank with one byte-strobed write port and one registered read port.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic             rd_en,
    input  logic             rd_hit,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem_q [NUM_REGS];

    // A read and a write on the same edge see the pre-write contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) mem_q[wr_idx] <= strobe_merge(mem_q[wr_idx], wr_data, wr_strb);
            if (rd_en) rd_data <= rd_hit ? mem_q[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder backing a bank of 32-bit registers; independent write and read FSMs.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-3:0] REG_LIMIT = (ADDR_WIDTH-2)'(NUM_REGS);

    wr_state_t               wr_state_q, wr_state_d;
    rd_state_t               rd_state_q, rd_state_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-3:0]   aw_idx_q, aw_idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    resp_t                   bresp_q, bresp_d, rresp_q, rresp_d;

    logic                    aw_fire, w_fire, ar_fire, commit, wr_hit, rd_hit;
    logic [ADDR_WIDTH-3:0]   wr_word, rd_word;
    logic [31:0]             wr_data;
    logic [3:0]              wr_strb;
    logic                    unused_byte_addr;

    assign unused_byte_addr = ^{AWADDR[1:0], ARADDR[1:0]};

    // Reset gating keeps the readies low during reset yet high in the first cycle after it.
    assign AWREADY = !reset && (wr_state_q == WR_IDLE) && !aw_held_q;
    assign WREADY  = !reset && (wr_state_q == WR_IDLE) && !w_held_q;
    assign ARREADY = !reset && (rd_state_q == RD_IDLE);
    assign BVALID  = (wr_state_q == WR_RESP);
    assign BRESP   = bresp_q;
    assign RVALID  = (rd_state_q == RD_DATA);
    assign RRESP   = rresp_q;

    assign aw_fire = AWVALID && AWREADY;
    assign w_fire  = WVALID && WREADY;
    assign ar_fire = ARVALID && ARREADY;

    // Commit uses whichever of AW/W is arriving now, falling back to the held copy.
    assign wr_word = aw_fire ? AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
    assign wr_data = w_fire ? WDATA : wdata_q;
    assign wr_strb = w_fire ? WSTRB : wstrb_q;
    assign rd_word = ARADDR[ADDR_WIDTH-1:2];
    assign wr_hit  = wr_word < REG_LIMIT;
    assign rd_hit  = rd_word < REG_LIMIT;
    assign commit  = (wr_state_q == WR_IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q || aw_fire;
        w_held_d   = w_held_q || w_fire;
        aw_idx_d   = aw_fire ? AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
        wdata_d    = w_fire ? WDATA : wdata_q;
        wstrb_d    = w_fire ? WSTRB : wstrb_q;
        bresp_d    = bresp_q;
        unique case (wr_state_q)
            WR_IDLE: begin
                if (commit) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bresp_d    = wr_hit ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: if (BREADY) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (ar_fire) begin
                    rresp_d    = rd_hit ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: if (RREADY) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
        end
    end

    axi4_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (commit && wr_hit),
        .wr_idx  (wr_word[IDX_W-1:0]),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (ar_fire),
        .rd_hit  (rd_hit),
        .rd_idx  (rd_word[IDX_W-1:0]),
        .rd_data (RDATA)
    );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: transaction-level register model plus per-cycle monitor.
module tb_axi4_lite_slave_regs;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]  WSTRB = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
    logic        BREADY = 1'b1, RREADY = 1'b1;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    always #5 clock = ~clock;

    axi4_lite_slave_regs #(
        .NUM_REGS   (16),
        .ADDR_WIDTH (32)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: registers indexed by addr/4; anything at or beyond 16 words is an error slot.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        int unsigned idx;
        idx = addr / 4;
        if (idx < 16) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
    endtask

    task automatic model_read(input logic [31:0] addr);
        int unsigned idx;
        idx = addr / 4;
        if (idx < 16) exp_r.push_back({2'b00, model[idx]});
        else          exp_r.push_back({2'b10, 32'h0});
    endtask

    // Response checker: every cycle a response is presented it must match the model.
    always @(negedge clock) begin
        logic [33:0] er;
        if (!reset && BVALID) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bvalid: got BVALID=1, expected no response");
            end else begin
                check("bresp", BRESP, exp_b[0]);
                if (BREADY) void'(exp_b.pop_front());
            end
            check("aw_w_ready_during_b", {AWREADY, WREADY}, 0);
        end
        if (!reset && RVALID) begin
            if (exp_r.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got RVALID=1, expected no response");
            end else begin
                er = exp_r[0];
                check("rdata", RDATA, er[31:0]);
                check("rresp", RRESP, er[33:32]);
                if (RREADY) void'(exp_r.pop_front());
            end
            check("ar_ready_during_r", ARREADY, 0);
        end
    end

    task automatic send_aw(input logic [31:0] addr);
        @(posedge clock); #1;
        AWADDR = addr; AWVALID = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 20 && !AWREADY; i++) @(negedge clock);
        check("awready_wait", AWREADY, 1);
        @(posedge clock); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        @(posedge clock); #1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 20 && !WREADY; i++) @(negedge clock);
        check("wready_wait", WREADY, 1);
        @(posedge clock); #1;
        WVALID = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        @(negedge clock);
        check("b_latency", BVALID, 1);
        resp = BRESP;
        for (int i = 0; i < 20 && BVALID; i++) @(negedge clock);
        check("b_drain", BVALID, 0);
    endtask

    // lead > 0: W goes lead cycles ahead of AW; lead < 0: AW goes first; 0: same cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, output logic [1:0] resp);
        model_write(addr, data, strb);
        if (lead == 0) begin
            @(posedge clock); #1;
            AWADDR = addr; AWVALID = 1'b1;
            WDATA = data; WSTRB = strb; WVALID = 1'b1;
            @(negedge clock);
            for (int i = 0; i < 20 && !(AWREADY && WREADY); i++) @(negedge clock);
            check("aw_w_ready_wait", {AWREADY, WREADY}, 2'b11);
            @(posedge clock); #1;
            AWVALID = 1'b0; WVALID = 1'b0;
        end else if (lead > 0) begin
            send_w(data, strb);
            repeat (lead) begin @(negedge clock); check("no_b_before_aw", BVALID, 0); end
            send_aw(addr);
        end else begin
            send_aw(addr);
            repeat (-lead) begin @(negedge clock); check("no_b_before_w", BVALID, 0); end
            send_w(data, strb);
        end
        wait_b(resp);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        model_read(addr);
        @(posedge clock); #1;
        ARADDR = addr; ARVALID = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 20 && !ARREADY; i++) @(negedge clock);
        check("arready_wait", ARREADY, 1);
        @(posedge clock); #1;
        ARVALID = 1'b0;
        @(negedge clock);
        check("r_latency", RVALID, 1);
        data = RDATA;
        resp = RRESP;
        for (int i = 0; i < 20 && RVALID; i++) @(negedge clock);
        check("r_drain", RVALID, 0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset behaviour.
        @(negedge clock);
        check("ready_in_reset", {AWREADY, WREADY, ARREADY}, 3'b000);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);
        check("valid_after_reset", {BVALID, RVALID}, 2'b00);
        check("rdata_after_reset", {RDATA, BRESP, RRESP}, 0);

        // AW+W together, then readback.
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, resp);
        check("wr04_bresp", resp, 2'b00);
        do_read(32'h04, data, resp);
        check("rd04_data", data, 32'hDEADBEEF);
        check("rd04_resp", resp, 2'b00);

        // W three cycles ahead of AW.
        do_write(32'h08, 32'h11223344, 4'hF, 3, resp);
        check("wr08_bresp", resp, 2'b00);
        do_read(32'h08, data, resp);
        check("rd08_data", data, 32'h11223344);

        // AW two cycles ahead of W, with a byte-address offset that must be ignored.
        do_write(32'h17, 32'hCAFEF00D, 4'hF, -2, resp);
        do_read(32'h14, data, resp);
        check("rd14_data", data, 32'hCAFEF00D);

        // Strobe merge and all-zero strobe.
        do_write(32'h0C, 32'hAABBCCDD, 4'hF, 0, resp);
        do_write(32'h0C, 32'h00000055, 4'b0001, 0, resp);
        do_read(32'h0C, data, resp);
        check("rd0c_merge", data, 32'hAABBCC55);
        do_write(32'h0C, 32'hFFFFFFFF, 4'b0000, 0, resp);
        check("wr0c_nostrb_bresp", resp, 2'b00);
        do_read(32'h0C, data, resp);
        check("rd0c_nostrb", data, 32'hAABBCC55);

        // Out of range.
        do_write(32'h40, 32'h12345678, 4'hF, 0, resp);
        check("wr40_bresp", resp, 2'b10);
        do_read(32'h40, data, resp);
        check("rd40_data", data, 32'h0);
        check("rd40_resp", resp, 2'b10);
        do_read(32'h00, data, resp);
        check("rd00_untouched", data, 32'h0);

        // Same-edge commit and read of one register returns the old value.
        do_write(32'h18, 32'h01010101, 4'hF, 0, resp);
        model_read(32'h18);
        model_write(32'h18, 32'h02020202, 4'hF);
        send_w(32'h02020202, 4'hF);
        @(posedge clock); #1;
        AWADDR = 32'h18; AWVALID = 1'b1; ARADDR = 32'h18; ARVALID = 1'b1;
        @(negedge clock);
        check("collide_ready", {AWREADY, ARREADY}, 2'b11);
        @(posedge clock); #1;
        AWVALID = 1'b0; ARVALID = 1'b0;
        @(negedge clock);
        check("collide_valid", {BVALID, RVALID}, 2'b11);
        check("collide_old_data", RDATA, 32'h01010101);
        @(negedge clock);
        check("collide_drain", {BVALID, RVALID}, 2'b00);
        do_read(32'h18, data, resp);
        check("rd18_new", data, 32'h02020202);

        // Backpressure on both response channels.
        BREADY = 1'b0; RREADY = 1'b0;
        model_read(32'h04);
        model_write(32'h10, 32'h5A5A5A5A, 4'hF);
        @(posedge clock); #1;
        AWADDR = 32'h10; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; ARADDR = 32'h04;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        @(negedge clock);
        check("bp_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge clock); #1;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check("bp_valids_held", {BVALID, RVALID}, 2'b11);
            check("bp_readies_low", {AWREADY, WREADY, ARREADY}, 3'b000);
            check("bp_rdata", RDATA, 32'hDEADBEEF);
        end
        @(posedge clock); #1;
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge clock);
        check("bp_release_hs", {BVALID, RVALID}, 2'b11);
        @(negedge clock);
        check("bp_release_drop", {BVALID, RVALID}, 2'b00);
        do_read(32'h10, data, resp);
        check("rd10_data", data, 32'h5A5A5A5A);

        // Reset in the middle of a write: AW accepted, W never sent.
        send_aw(32'h08);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(negedge clock);
        check("midrst_ready_after", {AWREADY, WREADY, ARREADY}, 3'b111);
        check("midrst_no_b", BVALID, 0);
        @(negedge clock);
        check("midrst_no_b2", BVALID, 0);
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), data, resp);
            check("midrst_cleared", data, 32'h0);
        end

        check("pending_b", exp_b.size(), 0);
        check("pending_r", exp_r.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected $finish");
        $fatal(1, "timeout");
    end

endmodule
